// File: rtl/riscv_v_mul_wb_stage.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_v_mul_wb_stage
//  Brief    : Writeback stage behind the vector multiplier. Accepts 128-bit
//             results through a valid/ready handshake and merges active
//             elements with the old vd value (vl, v0 mask, agnostic policy).
//             Merged results are held in a 2-entry FIFO that drives the VRF
//             write port. Also keeps performance counters and a sticky
//             osize error flag.
//  Revision : 1.0 - initial release
// ============================================================================
module riscv_v_mul_wb_stage #(
    parameter int DATA_WIDTH    = 128,
    parameter int NUM_BYTES     = DATA_WIDTH / 8,
    parameter int NUM_OSIZES    = 5,
    parameter bit MASK_AGNOSTIC = 1'b0,
    parameter bit TAIL_AGNOSTIC = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // upstream (multiplier) side
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_result,
    input  logic [DATA_WIDTH-1:0] in_vd_old,
    input  logic [NUM_OSIZES-1:0] in_osize_vector,
    input  logic [NUM_BYTES-1:0]  in_mask,
    input  logic                  in_vm,
    input  logic [4:0]            in_vl,
    input  logic [4:0]            in_vd_addr,
    // VRF write side
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [NUM_BYTES-1:0]  out_byte_we,
    output logic [4:0]            out_vd_addr,
    // status
    output logic [31:0]           perf_results,
    output logic [31:0]           perf_stalls,
    output logic                  err_osize
);

    localparam int c_IDX_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

    // FIFO occupancy doubles as the control state
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;
    logic   r_in_ready;

    logic   w_push;
    logic   w_pop;

    // merge datapath
    logic                  w_osize_onehot;
    logic [31:0]           w_osize_idx;
    logic [31:0]           w_max_elems;
    logic [31:0]           w_vl_ext;
    logic [31:0]           w_vl_eff;
    logic [DATA_WIDTH-1:0] w_merged_data;
    logic [NUM_BYTES-1:0]  w_merged_we;

    // FIFO storage (entries are already merged)
    logic [DATA_WIDTH-1:0] r_data_q [2];
    logic [NUM_BYTES-1:0]  r_we_q   [2];
    logic [4:0]            r_addr_q [2];
    logic                  r_wr_ptr;
    logic                  r_rd_ptr;

    logic [31:0]           r_perf_results;
    logic [31:0]           r_perf_stalls;
    logic                  r_err_osize;

    assign in_ready  = r_in_ready;
    assign out_valid = (r_state != ST_EMPTY);
    assign w_push    = in_valid & r_in_ready;
    assign w_pop     = out_valid & out_ready;

    // Head entry feeds the write port; it cannot change until popped because
    // pushes always target the other slot while the FIFO is non-empty.
    assign out_data    = r_data_q[r_rd_ptr];
    assign out_byte_we = r_we_q[r_rd_ptr];
    assign out_vd_addr = r_addr_q[r_rd_ptr];

    assign perf_results = r_perf_results;
    assign perf_stalls  = r_perf_stalls;
    assign err_osize    = r_err_osize;

    // Element width index (log2 of SEW/8) and the legality of the encoding
    always_comb begin
        w_osize_idx = '0;
        for (int i = 0; i < NUM_OSIZES; i++) begin
            if (in_osize_vector[i]) begin
                w_osize_idx = 32'(i);
            end
        end
        w_osize_onehot = $onehot(in_osize_vector);
    end

    // Clamp vl to the number of elements that fit in one register
    always_comb begin
        w_max_elems = 32'(NUM_BYTES) >> w_osize_idx;
        w_vl_ext    = {27'd0, in_vl};
        w_vl_eff    = (w_vl_ext < w_max_elems) ? w_vl_ext : w_max_elems;
    end

    // Per-byte merge: active bytes take the result, others follow the
    // tail/mask policy; an illegal osize makes every byte tail
    always_comb begin
        logic [31:0] w_elem;
        logic        w_tail;
        logic        w_active;
        w_merged_data = '0;
        w_merged_we   = '0;
        w_elem        = '0;
        w_tail        = 1'b0;
        w_active      = 1'b0;
        for (int b = 0; b < NUM_BYTES; b++) begin
            w_elem   = 32'(b) >> w_osize_idx;
            w_tail   = !w_osize_onehot || (w_elem >= w_vl_eff);
            w_active = !w_tail && (in_vm || in_mask[w_elem[c_IDX_W-1:0]]);
            w_merged_we[b] = w_active;
            if (w_active) begin
                w_merged_data[8*b +: 8] = in_result[8*b +: 8];
            end else if (w_tail) begin
                w_merged_data[8*b +: 8] = TAIL_AGNOSTIC ? 8'hFF : in_vd_old[8*b +: 8];
            end else begin
                w_merged_data[8*b +: 8] = MASK_AGNOSTIC ? 8'hFF : in_vd_old[8*b +: 8];
            end
        end
    end

    // Occupancy next-state; a full FIFO never sees a push
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_EMPTY: begin
                if (w_push) begin
                    w_state_next = ST_ONE;
                end
            end
            ST_ONE: begin
                if (w_push && !w_pop) begin
                    w_state_next = ST_FULL;
                end else if (w_pop && !w_push) begin
                    w_state_next = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (w_pop) begin
                    w_state_next = ST_ONE;
                end
            end
            default: begin
                w_state_next = ST_EMPTY;
            end
        endcase
    end

    // State register; in_ready is registered from the next state so it never
    // depends combinationally on out_ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_state_next;
            r_in_ready <= (w_state_next != ST_FULL);
        end
    end

    // FIFO storage and pointers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                r_data_q[i] <= '0;
                r_we_q[i]   <= '0;
                r_addr_q[i] <= '0;
            end
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
        end else begin
            if (w_push) begin
                r_data_q[r_wr_ptr] <= w_merged_data;
                r_we_q[r_wr_ptr]   <= w_merged_we;
                r_addr_q[r_wr_ptr] <= in_vd_addr;
                r_wr_ptr           <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
        end
    end

    // Performance counters, free-running with natural 32-bit wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_results <= '0;
            r_perf_stalls  <= '0;
        end else begin
            if (w_pop) begin
                r_perf_results <= r_perf_results + 32'd1;
            end
            if (out_valid && !out_ready) begin
                r_perf_stalls <= r_perf_stalls + 32'd1;
            end
        end
    end

    // Sticky flag for an accepted entry with a non-one-hot osize
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_osize <= 1'b0;
        end else if (w_push && !w_osize_onehot) begin
            r_err_osize <= 1'b1;
        end
    end

endmodule
`default_nettype wire
